// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite channel widths and response codes used by the slave,
// the master-side mux and the interconnect.
package axi_lite_pkg;

   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;
   localparam int RESP_W = 2;

   typedef enum logic [RESP_W-1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

endpackage

// File: rtl/sram_1r1w_be.sv
// Single-clock word RAM: one byte-enabled write port and one registered read
// port. A same-edge read of the word being written returns the old contents.
module sram_1r1w_be
   import axi_lite_pkg::*;
#(
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [STRB_W-1:0]        wbe,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // No reset on the array or read register so the tools can map to block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite slave in front of on-chip word RAM: independent AW/W capture, one
// outstanding write, one-cycle read latency and SLVERR outside the window.
module axi_lite_ram_slave
   import axi_lite_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    MEM_WORDS  = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] s_awaddr,
   input  logic                  s_awvalid,
   output logic                  s_awready,
   input  logic [DATA_W-1:0]     s_wdata,
   input  logic [STRB_W-1:0]     s_wstrb,
   input  logic                  s_wvalid,
   output logic                  s_wready,
   output logic [RESP_W-1:0]     s_bresp,
   output logic                  s_bvalid,
   input  logic                  s_bready,
   input  logic [ADDR_WIDTH-1:0] s_araddr,
   input  logic                  s_arvalid,
   output logic                  s_arready,
   output logic [DATA_W-1:0]     s_rdata,
   output logic [RESP_W-1:0]     s_rresp,
   output logic                  s_rvalid,
   input  logic                  s_rready
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_WORDS * 4);

   logic                  rst_done;
   logic                  aw_full, w_full, aw_err, r_err;
   logic [IDX_W-1:0]      aw_idx;
   logic [DATA_W-1:0]     w_data;
   logic [STRB_W-1:0]     w_strb;
   logic [ADDR_WIDTH-1:0] aw_off, ar_off;
   logic                  aw_hs, w_hs, ar_hs, commit;
   logic [DATA_W-1:0]     ram_q;

   // Offsets wrap below BASE_ADDR, so a single unsigned compare covers both bounds.
   assign aw_off = s_awaddr - BASE_ADDR;
   assign ar_off = s_araddr - BASE_ADDR;

   // rst_done keeps every ready low until the first edge after reset release.
   assign s_awready = rst_done && !aw_full && !s_bvalid;
   assign s_wready  = rst_done && !w_full && !s_bvalid;
   assign s_arready = rst_done && !s_rvalid;

   assign aw_hs  = s_awvalid && s_awready;
   assign w_hs   = s_wvalid && s_wready;
   assign ar_hs  = s_arvalid && s_arready;
   assign commit = aw_full && w_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rst_done <= 1'b0;
         aw_full  <= 1'b0;
         aw_err   <= 1'b0;
         aw_idx   <= '0;
         w_full   <= 1'b0;
         w_data   <= '0;
         w_strb   <= '0;
         s_bvalid <= 1'b0;
         s_bresp  <= RESP_OKAY;
         s_rvalid <= 1'b0;
         s_rresp  <= RESP_OKAY;
         r_err    <= 1'b0;
      end else begin
         rst_done <= 1'b1;
         if (aw_hs) begin
            aw_full <= 1'b1;
            aw_idx  <= aw_off[IDX_W+1:2];
            aw_err  <= !({1'b0, aw_off} < MEM_BYTES);
         end
         if (w_hs) begin
            w_full <= 1'b1;
            w_data <= s_wdata;
            w_strb <= s_wstrb;
         end
         if (commit) begin
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            s_bvalid <= 1'b1;
            s_bresp  <= aw_err ? RESP_SLVERR : RESP_OKAY;
         end else if (s_bvalid && s_bready) begin
            s_bvalid <= 1'b0;
         end
         if (ar_hs) begin
            s_rvalid <= 1'b1;
            r_err    <= !({1'b0, ar_off} < MEM_BYTES);
            s_rresp  <= ({1'b0, ar_off} < MEM_BYTES) ? RESP_OKAY : RESP_SLVERR;
         end else if (s_rvalid && s_rready) begin
            s_rvalid <= 1'b0;
         end
      end
   end

   // RAM read register is not reset; mask it so rdata is zero in reset and on errors.
   assign s_rdata = (s_rvalid && !r_err) ? ram_q : '0;

   sram_1r1w_be #(
      .DEPTH (MEM_WORDS)
   ) u_ram (
      .clk   (clk),
      .we    (commit && !aw_err),
      .waddr (aw_idx),
      .wdata (w_data),
      .wbe   (w_strb),
      .re    (ar_hs),
      .raddr (ar_off[IDX_W+1:2]),
      .rdata (ram_q)
   );

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Directed bench for axi_lite_ram_slave: handshake latency, strobes, SLVERR,
// backpressure, same-edge read/write collision and reset mid-write.
module tb_axi_lite_ram_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] s_awaddr = '0;
   logic        s_awvalid = 1'b0;
   logic        s_awready;
   logic [31:0] s_wdata = '0;
   logic [3:0]  s_wstrb = '0;
   logic        s_wvalid = 1'b0;
   logic        s_wready;
   logic [1:0]  s_bresp;
   logic        s_bvalid;
   logic        s_bready = 1'b0;
   logic [31:0] s_araddr = '0;
   logic        s_arvalid = 1'b0;
   logic        s_arready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rvalid;
   logic        s_rready = 1'b0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   axi_lite_ram_slave #(
      .ADDR_WIDTH (32),
      .MEM_WORDS  (1024),
      .BASE_ADDR  (32'h0000_0000)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .s_awaddr  (s_awaddr),
      .s_awvalid (s_awvalid),
      .s_awready (s_awready),
      .s_wdata   (s_wdata),
      .s_wstrb   (s_wstrb),
      .s_wvalid  (s_wvalid),
      .s_wready  (s_wready),
      .s_bresp   (s_bresp),
      .s_bvalid  (s_bvalid),
      .s_bready  (s_bready),
      .s_araddr  (s_araddr),
      .s_arvalid (s_arvalid),
      .s_arready (s_arready),
      .s_rdata   (s_rdata),
      .s_rresp   (s_rresp),
      .s_rvalid  (s_rvalid),
      .s_rready  (s_rready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
      int n;
      s_awaddr = a; s_awvalid = 1'b1;
      s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
      n = 0;
      while (!(s_awready && s_wready) && n < 20) begin cyc(); n++; end
      check("wr_ready_wait", {31'b0, (n < 20)}, 32'd1);
      cyc();
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      n = 0;
      while (!s_bvalid && n < 20) begin cyc(); n++; end
      check("wr_bvalid_wait", {31'b0, s_bvalid}, 32'd1);
      resp = s_bresp;
      s_bready = 1'b1;
      cyc();
      s_bready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n;
      s_araddr = a; s_arvalid = 1'b1;
      n = 0;
      while (!s_arready && n < 20) begin cyc(); n++; end
      check("rd_ready_wait", {31'b0, (n < 20)}, 32'd1);
      cyc();
      s_arvalid = 1'b0;
      check("rd_rvalid_latency", {31'b0, s_rvalid}, 32'd1);
      d = s_rdata;
      resp = s_rresp;
      s_rready = 1'b1;
      cyc();
      s_rready = 1'b0;
   endtask

   logic [31:0] rd;
   logic [1:0]  rr, br;

   initial begin
      // Reset state
      repeat (3) cyc();
      check("rst_awready", {31'b0, s_awready}, 32'd0);
      check("rst_wready",  {31'b0, s_wready},  32'd0);
      check("rst_arready", {31'b0, s_arready}, 32'd0);
      check("rst_bvalid",  {31'b0, s_bvalid},  32'd0);
      check("rst_rvalid",  {31'b0, s_rvalid},  32'd0);
      check("rst_bresp",   {30'b0, s_bresp},   32'd0);
      check("rst_rresp",   {30'b0, s_rresp},   32'd0);
      check("rst_rdata",   s_rdata,            32'd0);
      rst = 1'b0;
      check("rel_awready_low", {31'b0, s_awready}, 32'd0);
      cyc();
      check("rel_awready", {31'b0, s_awready}, 32'd1);
      check("rel_wready",  {31'b0, s_wready},  32'd1);
      check("rel_arready", {31'b0, s_arready}, 32'd1);

      // AW and W together, then read back
      s_awaddr = 32'h10; s_awvalid = 1'b1;
      s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF; s_wvalid = 1'b1;
      cyc();
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      check("t1_bvalid_early", {31'b0, s_bvalid}, 32'd0);
      check("t1_awready_busy", {31'b0, s_awready}, 32'd0);
      cyc();
      check("t1_bvalid", {31'b0, s_bvalid}, 32'd1);
      check("t1_bresp",  {30'b0, s_bresp},  32'd0);
      s_bready = 1'b1;
      cyc();
      s_bready = 1'b0;
      check("t1_bvalid_clr", {31'b0, s_bvalid}, 32'd0);
      check("t1_awready_back", {31'b0, s_awready}, 32'd1);
      s_araddr = 32'h10; s_arvalid = 1'b1;
      cyc();
      s_arvalid = 1'b0;
      check("t1_rvalid",  {31'b0, s_rvalid}, 32'd1);
      check("t1_rdata",   s_rdata, 32'hDEAD_BEEF);
      check("t1_rresp",   {30'b0, s_rresp}, 32'd0);
      check("t1_arready", {31'b0, s_arready}, 32'd0);
      s_rready = 1'b1;
      cyc();
      s_rready = 1'b0;
      check("t1_rvalid_clr", {31'b0, s_rvalid}, 32'd0);

      // W two cycles ahead of AW, partial strobe
      do_write(32'h14, 32'hFFFF_FFFF, 4'hF, br);
      check("t2_pre_bresp", {30'b0, br}, 32'd0);
      s_wdata = 32'h1234_5678; s_wstrb = 4'h3; s_wvalid = 1'b1;
      cyc();
      s_wvalid = 1'b0;
      check("t2_wready_busy", {31'b0, s_wready}, 32'd0);
      cyc();
      check("t2_no_b_yet", {31'b0, s_bvalid}, 32'd0);
      s_awaddr = 32'h14; s_awvalid = 1'b1;
      cyc();
      s_awvalid = 1'b0;
      check("t2_bvalid_early", {31'b0, s_bvalid}, 32'd0);
      cyc();
      check("t2_bvalid", {31'b0, s_bvalid}, 32'd1);
      check("t2_bresp",  {30'b0, s_bresp}, 32'd0);
      s_bready = 1'b1;
      cyc();
      s_bready = 1'b0;
      do_read(32'h14, rd, rr);
      check("t2_rdata", rd, 32'hFFFF_5678);
      check("t2_rresp", {30'b0, rr}, 32'd0);

      // Out of range: 0x1000 would alias word 0 if not rejected
      do_write(32'h0, 32'h1122_3344, 4'hF, br);
      do_write(32'h1000, 32'hCAFE_BABE, 4'hF, br);
      check("t3_bresp", {30'b0, br}, 32'd2);
      do_read(32'h0, rd, rr);
      check("t3_word0_kept", rd, 32'h1122_3344);
      do_read(32'h1000, rd, rr);
      check("t3_rdata", rd, 32'd0);
      check("t3_rresp", {30'b0, rr}, 32'd2);

      // Backpressure on B and R
      s_awaddr = 32'h18; s_awvalid = 1'b1;
      s_wdata = 32'h0F0F_0F0F; s_wstrb = 4'hF; s_wvalid = 1'b1;
      cyc();
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      cyc();
      for (int i = 0; i < 5; i++) begin
         check("t4_bvalid_hold",  {31'b0, s_bvalid}, 32'd1);
         check("t4_bresp_hold",   {30'b0, s_bresp}, 32'd0);
         check("t4_awready_hold", {31'b0, s_awready}, 32'd0);
         check("t4_wready_hold",  {31'b0, s_wready}, 32'd0);
         cyc();
      end
      s_bready = 1'b1;
      cyc();
      s_bready = 1'b0;
      s_araddr = 32'h18; s_arvalid = 1'b1;
      cyc();
      s_arvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("t4_rvalid_hold",  {31'b0, s_rvalid}, 32'd1);
         check("t4_rdata_hold",   s_rdata, 32'h0F0F_0F0F);
         check("t4_arready_hold", {31'b0, s_arready}, 32'd0);
         cyc();
      end
      s_rready = 1'b1;
      cyc();
      s_rready = 1'b0;

      // Same-edge collision: AR accepted on the commit edge sees old data
      do_write(32'h20, 32'h5555_5555, 4'hF, br);
      s_awaddr = 32'h20; s_awvalid = 1'b1;
      s_wdata = 32'hAAAA_AAAA; s_wstrb = 4'hF; s_wvalid = 1'b1;
      cyc();
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      s_araddr = 32'h20; s_arvalid = 1'b1;
      cyc();
      s_arvalid = 1'b0;
      check("t5_bvalid", {31'b0, s_bvalid}, 32'd1);
      check("t5_rvalid", {31'b0, s_rvalid}, 32'd1);
      check("t5_rdata_old", s_rdata, 32'h5555_5555);
      s_bready = 1'b1; s_rready = 1'b1;
      cyc();
      s_bready = 1'b0; s_rready = 1'b0;
      do_read(32'h20, rd, rr);
      check("t5_rdata_new", rd, 32'hAAAA_AAAA);

      // Reset with AW accepted but W never sent
      do_write(32'h24, 32'h7777_7777, 4'hF, br);
      s_awaddr = 32'h24; s_awvalid = 1'b1;
      cyc();
      s_awvalid = 1'b0;
      check("t6_aw_held", {31'b0, s_awready}, 32'd0);
      rst = 1'b1;
      #1;
      check("t6_rst_bvalid",  {31'b0, s_bvalid}, 32'd0);
      check("t6_rst_rvalid",  {31'b0, s_rvalid}, 32'd0);
      check("t6_rst_awready", {31'b0, s_awready}, 32'd0);
      repeat (2) cyc();
      rst = 1'b0;
      cyc();
      check("t6_awready", {31'b0, s_awready}, 32'd1);
      check("t6_wready",  {31'b0, s_wready}, 32'd1);
      repeat (3) cyc();
      check("t6_no_b", {31'b0, s_bvalid}, 32'd0);
      do_read(32'h24, rd, rr);
      check("t6_rdata_old", rd, 32'h7777_7777);
      check("t6_rresp", {30'b0, rr}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi_lite_ram_slave.md
Name: axi_lite_ram_slave

Overview:
- AXI4-Lite responder (slave) that terminates the address/data channels driven by the master-side mux/interconnect and backs them with on-chip word RAM.
- Used as boot/program memory: the bootloader writes the image, then the CPU reads and writes it.
- Implements all five channels (AW, W, B, AR, R) with independent AW/W acceptance, byte strobes, and SLVERR for out-of-range accesses.

Parameters:
- ADDR_WIDTH, 32, width of s_awaddr/s_araddr.
- MEM_WORDS, 1024, number of 32-bit words; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to MEM_WORDS*4.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_awaddr  in  ADDR_WIDTH  write byte address.
- s_awvalid  in  1  / s_awready  out  1  AW handshake.
- s_wdata  in  32  write data.
- s_wstrb  in  4  byte enables; bit i covers wdata[8i+7:8i].
- s_wvalid  in  1  / s_wready  out  1  W handshake.
- s_bresp  out  2  write response; 00 = OKAY, 10 = SLVERR.
- s_bvalid  in→out  1 (output)  / s_bready  in  1  B handshake.
- s_araddr  in  ADDR_WIDTH  read byte address.
- s_arvalid  in  1  / s_arready  out  1  AR handshake.
- s_rdata  out  32  / s_rresp  out  2  read data and response.
- s_rvalid  out  1  / s_rready  in  1  R handshake.

Behaviour:
- Reset (async assert, sync release):
  - awready, wready, bvalid, arready, rvalid are 0 during reset.
  - bresp, rresp and rdata are 0.
  - Holding registers are cleared. RAM contents are not reset.
- On the first edge after reset release, awready, wready and arready go to 1.
- Address decode:
  - idx = (addr - BASE_ADDR) >> 2. addr[1:0] is ignored; no unaligned error.
  - In range when BASE_ADDR <= addr < BASE_ADDR + 4*MEM_WORDS. Anything else is out of range.
- Write path (flags aw_full, w_full, bvalid):
  - s_awready = !aw_full && !s_bvalid; s_wready = !w_full && !s_bvalid.
  - AW handshake at edge E latches the address and sets aw_full. W handshake latches data/strobe and sets w_full. The two may occur in the same or different cycles, in either order.
  - Commit happens at the first edge where aw_full && w_full:
    - If in range, write the bytes enabled in wstrb; wstrb = 0 writes nothing and still returns OKAY.
    - If out of range, leave the RAM unchanged and set bresp = SLVERR.
    - Set bvalid = 1 and clear aw_full and w_full.
  - Latency: bvalid rises one cycle after the later of the AW/W handshakes.
  - B stays stable until s_bready. It clears at the bready && bvalid edge; the next AW/W can be accepted in the following cycle.
  - At most one write is outstanding.
- Read path:
  - s_arready = !s_rvalid.
  - AR handshake at edge E gives s_rvalid = 1 and registered s_rdata/s_rresp after E (1-cycle latency).
  - Out of range returns rdata = 0 and rresp = SLVERR.
  - R stays stable until s_rready and clears at the handshake edge. Maximum read throughput is one read per 2 cycles.
- Simultaneous events:
  - Read and write paths are fully independent.
  - If a read samples the same word that commits on the same edge, the read returns the old (pre-write) value.
  - A new AW arriving while W is still pending is accepted as long as the slot is free.
- Reset mid-operation drops all pending AW/W/AR, bvalid and rvalid. A write not yet committed never reaches the RAM.
- bvalid/rvalid never depend combinationally on the valid inputs. Ready outputs depend only on registered state.

Decomposition:
- Shared package axi_lite_pkg:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - Channel-width constants reused by axi_master_mux and the interconnect.
- Sub-module sram_1r1w_be holds the RAM array:
  - one write port with 4-bit byte enable, one registered read port, read-before-write on collision.
  - Parameterized by depth; infers block RAM.

Test Plan:
- AW and W in the same cycle: addr 0x10, data 0xDEADBEEF, strb 0xF -> bvalid 1 cycle later, bresp 00. Then AR 0x10 -> rvalid next cycle, rdata 0xDEADBEEF, rresp 00.
- W two cycles before AW: addr 0x14, strb 0x3, data 0x1234_5678 over prior 0xFFFF_FFFF -> read 0x14 returns 0xFFFF_5678.
- Out of range: AW = BASE + 4*MEM_WORDS -> bresp 10 and RAM unchanged. AR at the same address -> rdata 0, rresp 10.
- Backpressure: bready held 0 for 5 cycles -> bvalid, bresp stable and awready/wready stay 0. rready held 0 -> rdata stable and arready 0.
- Same-edge collision: write 0xAAAA_AAAA to 0x20 (old 0x5555_5555) committing on the edge where AR 0x20 is accepted -> rdata 0x5555_5555. A later read returns 0xAAAA_AAAA.
- Reset mid-write: AW accepted, W not sent, assert rst -> all valids 0 and no B. After release, read of that address returns the old value.
